// File: rtl/hpi_access_ctrl.sv
// Avalon-MM slave to Cypress-style HPI bridge: one access per Avalon request,
// sequenced as setup / strobe / hold / done / recovery, all pin outputs registered.
module hpi_access_ctrl #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 4,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_hpi_address,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in,
    output logic        busy
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               dir_wr, dir_wr_nxt;
    logic               req;
    logic               active_nxt;

    assign req         = chipselect & (read | write);
    assign waitrequest = req & (state != DONE);
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dir_wr_nxt = dir_wr;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt  = SETUP;
                    cnt_nxt    = CNT_W'(SETUP_CYC - 1);
                    dir_wr_nxt = write;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (RECOVERY_CYC == 0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = RECOVER;
                    cnt_nxt   = CNT_W'(RECOVERY_CYC - 1);
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pin levels are decoded from the next state so they change on the same edge as the state.
    assign active_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= '0;
            dir_wr           <= 1'b0;
            otg_hpi_cs_n     <= 1'b1;
            otg_hpi_r_n      <= 1'b1;
            otg_hpi_w_n      <= 1'b1;
            otg_hpi_data_oe  <= 1'b0;
            otg_hpi_address  <= '0;
            otg_hpi_data_out <= '0;
            readdata         <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            dir_wr          <= dir_wr_nxt;
            otg_hpi_cs_n    <= ~active_nxt;
            otg_hpi_r_n     <= ~((state_nxt == STROBE) & ~dir_wr_nxt);
            otg_hpi_w_n     <= ~((state_nxt == STROBE) & dir_wr_nxt);
            otg_hpi_data_oe <= active_nxt & dir_wr_nxt;
            if (state == IDLE && req) begin
                otg_hpi_address <= address;
                if (write) begin
                    otg_hpi_data_out <= writedata;
                end
            end
            // Sample on the edge that closes the final strobe cycle, while r_n is still low.
            if (state == STROBE && cnt == '0 && !dir_wr) begin
                readdata <= otg_hpi_data_in;
            end
        end
    end

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Scoreboard bench for hpi_access_ctrl: default-timing instance checked through
// Avalon and HPI monitors, plus a re-parameterised instance checked directly.
module tb_hpi_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [15:0] writedata, readdata;
    logic        waitrequest;
    logic [1:0]  hpi_addr;
    logic        cs_n, r_n, w_n, oe, busy;
    logic [15:0] data_out, data_in;

    logic [1:0]  b_address;
    logic        b_chipselect, b_read, b_write;
    logic [15:0] b_writedata, b_readdata;
    logic        b_waitrequest;
    logic [1:0]  b_hpi_addr;
    logic        b_cs_n, b_r_n, b_w_n, b_oe, b_busy;
    logic [15:0] b_data_out, b_data_in;

    always #5 clk = ~clk;

    hpi_access_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .otg_hpi_address(hpi_addr), .otg_hpi_cs_n(cs_n),
        .otg_hpi_r_n(r_n), .otg_hpi_w_n(w_n), .otg_hpi_data_out(data_out),
        .otg_hpi_data_oe(oe), .otg_hpi_data_in(data_in), .busy(busy)
    );

    hpi_access_ctrl #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .RECOVERY_CYC(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(b_address), .chipselect(b_chipselect),
        .read(b_read), .write(b_write), .writedata(b_writedata), .readdata(b_readdata),
        .waitrequest(b_waitrequest), .otg_hpi_address(b_hpi_addr), .otg_hpi_cs_n(b_cs_n),
        .otg_hpi_r_n(b_r_n), .otg_hpi_w_n(b_w_n), .otg_hpi_data_out(b_data_out),
        .otg_hpi_data_oe(b_oe), .otg_hpi_data_in(b_data_in), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          exp_cyc;
        logic [15:0] rdata;
        string       name;
    } av_exp_t;

    typedef struct {
        int          cs;
        int          w;
        int          r;
        logic [1:0]  addr;
        logic [15:0] wdata;
        int          gap;
        string       name;
    } hpi_exp_t;

    av_exp_t  av_q[$];
    hpi_exp_t hpi_q[$];

    // Avalon-side monitor: every accepted request must match the next expected completion.
    av_exp_t av_e;
    always @(negedge clk) begin
        if (reset_n && chipselect && (read || write) && !waitrequest) begin
            if (av_q.size() == 0) begin
                check("av_unexpected_completion", 1, 0);
            end else begin
                av_e = av_q.pop_front();
                check({av_e.name, "_latency_cycle"}, cyc, av_e.exp_cyc);
                check({av_e.name, "_readdata"}, int'(readdata), int'(av_e.rdata));
            end
        end
    end

    // HPI-side monitor: measures each chip-select window and the idle gap before it.
    int          cs_cnt = 0, w_cnt = 0, r_cnt = 0, oe_cnt = 0;
    int          gap_cnt = 0, idle_cnt = 0, last_gap = 0, last_idle = 0;
    logic        in_txn = 1'b0, strobe_ok = 1'b1, addr_ok = 1'b1;
    logic [1:0]  seen_addr = '0;
    logic [15:0] seen_wdata = '0;
    hpi_exp_t    hpi_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            in_txn   = 1'b0;
            gap_cnt  = 0;
            idle_cnt = 0;
        end else if (!cs_n) begin
            if (!in_txn) begin
                in_txn     = 1'b1;
                last_gap   = gap_cnt;
                last_idle  = idle_cnt;
                cs_cnt     = 0;
                w_cnt      = 0;
                r_cnt      = 0;
                oe_cnt     = 0;
                strobe_ok  = 1'b1;
                addr_ok    = 1'b1;
                seen_addr  = hpi_addr;
                seen_wdata = '0;
            end
            cs_cnt++;
            if (!w_n) begin
                w_cnt++;
                seen_wdata = data_out;
            end
            if (!r_n) r_cnt++;
            if (oe) oe_cnt++;
            if (!r_n && !w_n) strobe_ok = 1'b0;
            if (hpi_addr != seen_addr) addr_ok = 1'b0;
        end else begin
            if (in_txn) begin
                in_txn = 1'b0;
                if (hpi_q.size() == 0) begin
                    check("hpi_unexpected_txn", 1, 0);
                end else begin
                    hpi_e = hpi_q.pop_front();
                    check({hpi_e.name, "_cs_low_cycles"}, cs_cnt, hpi_e.cs);
                    check({hpi_e.name, "_w_low_cycles"}, w_cnt, hpi_e.w);
                    check({hpi_e.name, "_r_low_cycles"}, r_cnt, hpi_e.r);
                    check({hpi_e.name, "_oe_cycles"}, oe_cnt, (hpi_e.w > 0) ? hpi_e.cs : 0);
                    check({hpi_e.name, "_hpi_address"}, int'(seen_addr), int'(hpi_e.addr));
                    check({hpi_e.name, "_addr_stable"}, int'(addr_ok), 1);
                    check({hpi_e.name, "_strobes_exclusive"}, int'(strobe_ok), 1);
                    if (hpi_e.w > 0)
                        check({hpi_e.name, "_data_out"}, int'(seen_wdata), int'(hpi_e.wdata));
                    if (hpi_e.gap >= 0) begin
                        check({hpi_e.name, "_cs_high_gap"}, last_gap, hpi_e.gap);
                        check({hpi_e.name, "_idle_in_gap"}, last_idle, 1);
                    end
                end
                gap_cnt  = 0;
                idle_cnt = 0;
            end
            gap_cnt++;
            if (!busy) idle_cnt++;
            if (!r_n || !w_n) check("strobe_with_cs_high", 0, 1);
        end
    end

    logic [15:0] rd_model = '0;

    task automatic issue(input logic rd, input logic wr, input logic [1:0] a, input logic [15:0] wd);
        @(posedge clk);
        #1;
        chipselect = 1'b1;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
    endtask

    task automatic release_req();
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!waitrequest) return;
        end
        check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic push_av(input int exp_cyc, input string name);
        av_exp_t e;
        e.exp_cyc = exp_cyc;
        e.rdata   = rd_model;
        e.name    = name;
        av_q.push_back(e);
    endtask

    task automatic push_hpi(input int w, input int r, input logic [1:0] a, input logic [15:0] wd,
                            input int gap, input string name);
        hpi_exp_t e;
        e.cs    = 6;
        e.w     = w;
        e.r     = r;
        e.addr  = a;
        e.wdata = wd;
        e.gap   = gap;
        e.name  = name;
        hpi_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int k;
        reset_n = 1'b0;
        {chipselect, read, write} = 3'b000;
        address = '0; writedata = '0; data_in = '0;
        {b_chipselect, b_read, b_write} = 3'b000;
        b_address = '0; b_writedata = '0; b_data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_r_w_n", int'({r_n, w_n}), 3);
        check("rst_oe", int'(oe), 0);
        check("rst_hpi_address", int'(hpi_addr), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_readdata", int'(readdata), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // write addr 2, 0x1234
        issue(1'b0, 1'b1, 2'd2, 16'h1234);
        push_av(cyc + 7, "wr1");
        push_hpi(4, 0, 2'd2, 16'h1234, -1, "wr1");
        wait_done("wr1");
        release_req();
        wait_idle("wr1");

        // read addr 0 returning 0xBEEF
        data_in = 16'hBEEF;
        issue(1'b1, 1'b0, 2'd0, 16'h0000);
        rd_model = 16'hBEEF;
        push_av(cyc + 7, "rd1");
        push_hpi(0, 4, 2'd0, 16'h0000, -1, "rd1");
        wait_done("rd1");
        release_req();
        wait_idle("rd1");

        // write must not disturb readdata
        data_in = 16'h0000;
        issue(1'b0, 1'b1, 2'd1, 16'h5A5A);
        push_av(cyc + 7, "wr2");
        push_hpi(4, 0, 2'd1, 16'h5A5A, -1, "wr2");
        wait_done("wr2");
        release_req();
        wait_idle("wr2");

        // read and write together behave as a write
        data_in = 16'h7777;
        issue(1'b1, 1'b1, 2'd3, 16'hC0DE);
        push_av(cyc + 7, "rdwr");
        push_hpi(4, 0, 2'd3, 16'hC0DE, -1, "rdwr");
        wait_done("rdwr");
        release_req();
        wait_idle("rdwr");

        // back-to-back reads with the request held through DONE
        data_in = 16'h1111;
        issue(1'b1, 1'b0, 2'd1, 16'h0000);
        rd_model = 16'h1111;
        push_av(cyc + 7, "b2b_a");
        push_hpi(0, 4, 2'd1, 16'h0000, -1, "b2b_a");
        wait_done("b2b_a");
        c = cyc;
        data_in  = 16'h2222;
        rd_model = 16'h2222;
        push_av(c + 10, "b2b_b");
        push_hpi(0, 4, 2'd1, 16'h0000, 4, "b2b_b");
        wait_done("b2b_b");
        release_req();
        wait_idle("b2b_b");

        // request withdrawn mid-sequence: HPI cycle still runs to completion
        issue(1'b0, 1'b1, 2'd2, 16'h0F0F);
        push_hpi(4, 0, 2'd2, 16'h0F0F, -1, "drop");
        @(posedge clk);
        release_req();
        wait_idle("drop");

        // asynchronous reset in the middle of a read strobe
        data_in = 16'h3333;
        issue(1'b1, 1'b0, 2'd0, 16'h0000);
        repeat (3) @(posedge clk);
        #2;
        check("abort_in_strobe_r_n", int'(r_n), 0);
        chipselect = 1'b0;
        read       = 1'b0;
        reset_n    = 1'b0;
        #1;
        check("abort_cs_n", int'(cs_n), 1);
        check("abort_r_w_n", int'({r_n, w_n}), 3);
        check("abort_busy", int'(busy), 0);
        check("abort_readdata", int'(readdata), 0);
        rd_model = 16'h0000;
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        issue(1'b0, 1'b1, 2'd0, 16'hAAAA);
        push_av(cyc + 7, "post_rst_wr");
        push_hpi(4, 0, 2'd0, 16'hAAAA, -1, "post_rst_wr");
        wait_done("post_rst_wr");
        release_req();
        wait_idle("post_rst_wr");

        // alternate timing: SETUP 2, STROBE 1, HOLD 3, no recovery
        @(posedge clk);
        #1;
        b_chipselect = 1'b1; b_write = 1'b1; b_address = 2'd1; b_writedata = 16'h4321;
        k = cyc;
        c = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!b_waitrequest) begin
                c = cyc;
                break;
            end
        end
        check("alt_wr_latency", c - k, 7);
        check("alt_wr_busy_in_done", int'(b_busy), 1);
        @(posedge clk);
        #1 {b_chipselect, b_write} = 2'b00;
        @(negedge clk);
        check("alt_wr_idle_after_done", int'(b_busy), 0);

        b_data_in = 16'hA5A5;
        @(posedge clk);
        #1;
        b_chipselect = 1'b1; b_read = 1'b1; b_address = 2'd0;
        k = cyc;
        c = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!b_waitrequest) begin
                c = cyc;
                break;
            end
        end
        check("alt_rd_latency", c - k, 7);
        check("alt_rd_readdata", int'(b_readdata), 16'hA5A5);
        @(posedge clk);
        #1 {b_chipselect, b_read} = 2'b00;
        @(negedge clk);
        check("alt_rd_idle_after_done", int'(b_busy), 0);

        repeat (5) @(negedge clk);
        check("av_queue_drained", av_q.size(), 0);
        check("hpi_queue_drained", hpi_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
